// File: rtl/divisor_seq_param.sv
// ---------------------------------------------------------------------------
// divisor_seq_param
//   Sequential restoring integer divider, signed or unsigned, retiring
//   BITS_PER_CYCLE quotient bits per clock.
//   Flow: IDLE -start-> LOAD -> ITER (SIZE/BITS_PER_CYCLE cycles) -> FIX -> DONE.
//   Results are registered in FIX and held in DONE until the next start.
//
// Parameters
//   SIZE            operand/result width (>= 4)
//   BITS_PER_CYCLE  quotient bits per ITER cycle: 1, 2 or 4, must divide SIZE
//
// Ports
//   clk, rst_n          clock (rising), async active-low reset
//   start               request, accepted only in IDLE or DONE
//   con_signo           1 = signed two's complement, 0 = unsigned
//   numerador           dividend
//   denominador         divisor
//   cociente, resto     quotient / remainder, valid while done
//   done                result valid (level)
//   busy                operation in flight (LOAD/ITER/FIX)
//   ovf                 signed min_neg / -1
//   div_cero            divisor was zero
//
// Build option
//   DIVISOR_DBZ_EN  detect a zero divisor in LOAD and short-cut to FIX;
//                   without it div_cero is tied low and a zero divisor
//                   runs the full restoring sequence.
// ---------------------------------------------------------------------------
module divisor_seq_param #(
  parameter int SIZE           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            con_signo,
  input  logic [SIZE-1:0] numerador,
  input  logic [SIZE-1:0] denominador,
  output logic [SIZE-1:0] cociente,
  output logic [SIZE-1:0] resto,
  output logic            done,
  output logic            busy,
  output logic            ovf,
  output logic            div_cero
);

  localparam int NITER = SIZE / BITS_PER_CYCLE;
  localparam int CW    = $clog2(NITER + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_ITER = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  generate
    if (SIZE < 4 || !(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4) ||
        (SIZE % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
      $error("divisor_seq_param: illegal SIZE / BITS_PER_CYCLE combination");
    end
  endgenerate

  logic [2:0]      state_q, state_d;
  logic            mode_q;
  logic [SIZE-1:0] num_q, den_q;     // raw operands captured on the accepting edge
  logic [SIZE-1:0] dmag_q;
  logic [SIZE-1:0] rem_q, rem_d;     // partial remainder, always < dmag between steps
  logic [SIZE-1:0] qd_q, qd_d;       // dividend shifts out MSB-first, quotient shifts in
  logic            qneg_q, rneg_q, ovf_pend_q;
  logic [CW-1:0]   cnt_q;
  logic [SIZE-1:0] coc_q, res_q;
  logic            done_q, busy_q, ovf_q;

  logic            accept, nneg, dneg, min_ovf;
  logic [SIZE-1:0] nmag, dmag;

  assign accept  = start && (state_q == S_IDLE || state_q == S_DONE);
  assign nneg    = mode_q & num_q[SIZE-1];
  assign dneg    = mode_q & den_q[SIZE-1];
  assign nmag    = nneg ? -num_q : num_q;
  assign dmag    = dneg ? -den_q : den_q;
  assign min_ovf = mode_q && (num_q == {1'b1, {(SIZE-1){1'b0}}}) && (den_q == '1);

`ifdef DIVISOR_DBZ_EN
  logic den_zero, dbz_pend_q, dbz_q;
  assign den_zero = (den_q == '0);
`endif

  // BITS_PER_CYCLE restoring steps chained combinationally. The shifted
  // remainder needs SIZE+1 bits; after a step it is back below dmag.
  always_comb begin
    logic [SIZE:0] sh, trial;
    rem_d = rem_q;
    qd_d  = qd_q;
    sh    = '0;
    trial = '0;
    for (int b = 0; b < BITS_PER_CYCLE; b++) begin
      sh    = {rem_d, qd_d[SIZE-1]};
      qd_d  = {qd_d[SIZE-2:0], 1'b0};
      trial = sh - {1'b0, dmag_q};
      if (!trial[SIZE]) begin
        rem_d   = trial[SIZE-1:0];
        qd_d[0] = 1'b1;
      end else begin
        rem_d   = sh[SIZE-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_LOAD;
      S_LOAD: begin
        state_d = S_ITER;
`ifdef DIVISOR_DBZ_EN
        if (den_zero) state_d = S_FIX;
`endif
      end
      S_ITER:  if (cnt_q == '0) state_d = S_FIX;
      S_FIX:   state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      mode_q     <= 1'b0;
      num_q      <= '0;
      den_q      <= '0;
      dmag_q     <= '0;
      rem_q      <= '0;
      qd_q       <= '0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      ovf_pend_q <= 1'b0;
      cnt_q      <= '0;
      coc_q      <= '0;
      res_q      <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
`ifdef DIVISOR_DBZ_EN
      dbz_pend_q <= 1'b0;
      dbz_q      <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        mode_q <= con_signo;
        num_q  <= numerador;
        den_q  <= denominador;
        done_q <= 1'b0;
        ovf_q  <= 1'b0;
        busy_q <= 1'b1;
`ifdef DIVISOR_DBZ_EN
        dbz_q  <= 1'b0;
`endif
      end
      case (state_q)
        S_LOAD: begin
          qd_q       <= nmag;
          rem_q      <= '0;
          dmag_q     <= dmag;
          qneg_q     <= nneg ^ dneg;
          rneg_q     <= nneg;
          ovf_pend_q <= min_ovf;
          cnt_q      <= CW'(NITER - 1);
`ifdef DIVISOR_DBZ_EN
          dbz_pend_q <= den_zero;
`endif
        end
        S_ITER: begin
          qd_q  <= qd_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q - 1'b1;
        end
        S_FIX: begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          // min_neg / -1 needs no special case: |q| = 2^(SIZE-1) negates to itself.
          coc_q  <= qneg_q ? -qd_q : qd_q;
          res_q  <= rneg_q ? -rem_q : rem_q;
          ovf_q  <= ovf_pend_q;
`ifdef DIVISOR_DBZ_EN
          if (dbz_pend_q) begin
            coc_q <= '1;
            res_q <= num_q;
            ovf_q <= 1'b0;
            dbz_q <= 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign cociente = coc_q;
  assign resto    = res_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign ovf      = ovf_q;
`ifdef DIVISOR_DBZ_EN
  assign div_cero = dbz_q;
`else
  assign div_cero = 1'b0;
`endif

endmodule

// File: tb/tb_divisor_seq_param.sv
module tb_divisor_seq_param;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start1 = 1'b0, start4 = 1'b0;
  logic        con_signo = 1'b0;
  logic [31:0] numerador = '0, denominador = '0;
  logic [31:0] q1, r1, q4, r4;
  logic        done1, busy1, ovf1, dz1, done4, busy4, ovf4, dz4;

  always #5 clk = ~clk;

  divisor_seq_param #(.SIZE(32), .BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .con_signo(con_signo),
    .numerador(numerador), .denominador(denominador),
    .cociente(q1), .resto(r1), .done(done1), .busy(busy1), .ovf(ovf1), .div_cero(dz1));

  divisor_seq_param #(.SIZE(32), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .con_signo(con_signo),
    .numerador(numerador), .denominador(denominador),
    .cociente(q4), .resto(r4), .done(done4), .busy(busy4), .ovf(ovf4), .div_cero(dz4));

`ifdef DIVISOR_DBZ_EN
  localparam bit DBZ = 1'b1;
`else
  localparam bit DBZ = 1'b0;
`endif

  int n_cmp = 0, n_err = 0;

  // selected DUT view
  logic        sel = 1'b0;
  logic [31:0] q_m, r_m;
  logic        done_m, busy_m, ovf_m, dz_m;
  always_comb begin
    q_m = sel ? q4 : q1;       r_m = sel ? r4 : r1;
    done_m = sel ? done4 : done1; busy_m = sel ? busy4 : busy1;
    ovf_m = sel ? ovf4 : ovf1; dz_m = sel ? dz4 : dz1;
  end

  // expectation for the transaction in flight
  logic [31:0] exp_q, exp_r;
  logic        exp_ovf, exp_dz;
  int          exp_lat;
  bit          track = 1'b0;
  int          cyc;
  logic [31:0] prev_q [2] = '{32'd0, 32'd0};
  logic [31:0] prev_r [2] = '{32'd0, 32'd0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: plain arithmetic on the operand values.
  function automatic void model(input bit s, input logic [31:0] n, input logic [31:0] d,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic ov, output logic dz);
    longint sn, sd;
    ov = 1'b0; dz = 1'b0;
    if (d == 32'd0) begin
      if (DBZ) begin
        q = 32'hFFFF_FFFF; r = n; dz = 1'b1;
      end else begin
        // all-ones magnitude, negated when the dividend is negative
        q = (s && n[31]) ? 32'd1 : 32'hFFFF_FFFF;
        r = n;
      end
    end else if (!s) begin
      q = n / d; r = n % d;
    end else if (n == 32'h8000_0000 && d == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0; ov = 1'b1;
    end else begin
      sn = longint'(signed'(n));
      sd = longint'(signed'(d));
      q = 32'(sn / sd);
      r = 32'(sn % sd);
    end
  endfunction

  // Checks every cycle of a tracked transaction.
  always @(negedge clk) begin
    if (track) begin
      cyc++;
      if (cyc < exp_lat) begin
        chk("busy_inflight", 32'(busy_m), 32'd1);
        chk("done_inflight", 32'(done_m), 32'd0);
        chk("q_kept_inflight", q_m, prev_q[int'(sel)]);
        chk("r_kept_inflight", r_m, prev_r[int'(sel)]);
        if (cyc == 0) begin
          chk("ovf_dropped", 32'(ovf_m), 32'd0);
          chk("dz_dropped", 32'(dz_m), 32'd0);
        end
      end else begin
        chk("done_at_latency", 32'(done_m), 32'd1);
        chk("busy_at_done", 32'(busy_m), 32'd0);
        chk("cociente", q_m, exp_q);
        chk("resto", r_m, exp_r);
        chk("ovf", 32'(ovf_m), 32'(exp_ovf));
        chk("div_cero", 32'(dz_m), 32'(exp_dz));
        prev_q[int'(sel)] = exp_q;
        prev_r[int'(sel)] = exp_r;
        track = 1'b0;
      end
    end
  end

  task automatic run(input bit sl, input bit s, input logic [31:0] n, input logic [31:0] d,
                     input int glitch);
    bit tmo;
    model(s, n, d, exp_q, exp_r, exp_ovf, exp_dz);
    exp_lat = (DBZ && d == 32'd0) ? 2 : (sl ? 10 : 34);
    @(negedge clk);
    sel = sl; con_signo = s; numerador = n; denominador = d;
    if (sl) start4 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    cyc = -1; track = 1'b1;
    #1;
    start1 = 1'b0; start4 = 1'b0;
    con_signo = ~s; numerador = $urandom; denominador = $urandom;
    for (int i = 0; i < exp_lat + 10 && track; i++) begin
      @(negedge clk);
      if (i == glitch) begin
        if (sl) start4 = 1'b1; else start1 = 1'b1;
      end else begin
        start1 = 1'b0; start4 = 1'b0;
      end
    end
    start1 = 1'b0; start4 = 1'b0;
    tmo = track;
    if (tmo) begin
      n_cmp++; n_err++;
      $display("FAIL timeout: done not seen within %0d cycles", exp_lat + 10);
      track = 1'b0;
    end else begin
      repeat (2) @(negedge clk);
      chk("done_held", 32'(done_m), 32'd1);
      chk("q_held", q_m, exp_q);
      chk("r_held", r_m, exp_r);
    end
  endtask

  // Directed vector with hand-computed result; also pins the model.
  task automatic run_lit(input bit sl, input bit s, input logic [31:0] n, input logic [31:0] d,
                         input logic [31:0] lq, input logic [31:0] lr, input bit lov,
                         input bit ldz, input int glitch);
    run(sl, s, n, d, glitch);
    chk("lit_q", q_m, lq);
    chk("lit_r", r_m, lr);
    chk("lit_ovf", 32'(ovf_m), 32'(lov));
    chk("lit_dz", 32'(dz_m), 32'(ldz));
    chk("model_q", exp_q, lq);
    chk("model_r", exp_r, lr);
  endtask

  function automatic logic [31:0] rnd32();
    logic [31:0] v;
    case ($urandom_range(0, 4))
      0: v = 32'($urandom_range(0, 20));
      1: case ($urandom_range(0, 4))
           0: v = 32'd0;
           1: v = 32'd1;
           2: v = 32'hFFFF_FFFF;
           3: v = 32'h8000_0000;
           default: v = 32'h7FFF_FFFF;
         endcase
      2: v = -32'($urandom_range(1, 20));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_q1", q1, 32'd0);           chk("rst_r1", r1, 32'd0);
    chk("rst_flags1", {28'd0, done1, busy1, ovf1, dz1}, 32'd0);
    chk("rst_flags4", {28'd0, done4, busy4, ovf4, dz4}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_done1", 32'(done1), 32'd0);

    run_lit(0, 1, 32'd100, 32'd7, 32'd14, 32'd2, 0, 0, -1);
    run_lit(0, 1, -32'd100, 32'd7, -32'd14, -32'd2, 0, 0, -1);
    run_lit(0, 1, 32'd100, -32'd7, -32'd14, 32'd2, 0, 0, -1);
    run_lit(0, 1, -32'd100, -32'd7, 32'd14, -32'd2, 0, 0, -1);
    run_lit(0, 0, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 32'd1, 0, 0, -1);
    run_lit(0, 1, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'hFFFF_FFFF, 0, 0, -1);
    run_lit(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1, 0, -1);
    run_lit(0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 0, 0, -1);
    run_lit(0, 1, 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 0, DBZ, -1);
    // start pulsed mid-ITER must not disturb the running division
    run_lit(0, 0, 32'd1000, 32'd9, 32'd111, 32'd1, 0, 0, 5);
    // radix-4 instance
    run_lit(1, 1, 32'd100, 32'd7, 32'd14, 32'd2, 0, 0, -1);
    run_lit(1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1, 0, -1);
    run_lit(1, 0, 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 0, DBZ, -1);

    // reset mid-ITER aborts immediately
    @(negedge clk);
    sel = 1'b0; con_signo = 1'b1; numerador = 32'd100; denominador = 32'd7; start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy1", 32'(busy1), 32'd0);
    chk("abort_q1", q1, 32'd0);
    chk("abort_r1", r1, 32'd0);
    chk("abort_flags1", {29'd0, done1, ovf1, dz1}, 32'd0);
    chk("abort_q4", q4, 32'd0);
    chk("abort_done4", 32'(done4), 32'd0);
    prev_q = '{32'd0, 32'd0};
    prev_r = '{32'd0, 32'd0};
    @(negedge clk) rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_abort_done1", 32'(done1), 32'd0);
    chk("post_abort_busy1", 32'(busy1), 32'd0);

    // random against the model
    for (int k = 0; k < 300; k++) run(0, 1'($urandom_range(0, 1)), rnd32(), rnd32(), -1);
    for (int k = 0; k < 2000; k++) run(1, 1'($urandom_range(0, 1)), rnd32(), rnd32(), -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
